// File: rtl/strobe_memory_pkg.sv
// Shared constants, types and address decode for the byte-lane data memory.
package strobe_memory_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef struct packed {
    logic [63:0] index;
    logic        err;
  } decode_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Misaligned or past-the-end addresses are flagged instead of aliasing.
  function automatic decode_t decode_addr(input logic [63:0] addr,
                                          input int unsigned lanes,
                                          input int unsigned words);
    decode_t     d;
    logic [63:0] lane_mask;
    lane_mask = 64'(lanes) - 64'd1;
    d.index   = addr >> clog2(lanes);
    d.err     = ((addr & lane_mask) != '0) || (d.index >= 64'(words));
    return d;
  endfunction

endpackage

// File: rtl/strobe_memory_resp_fifo.sv
// Two-entry synchronous FIFO holding read responses in request order.
module strobe_memory_resp_fifo #(
  parameter int unsigned pWidth = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [pWidth-1:0] push_data,
  input  logic              pop,
  output logic [pWidth-1:0] head,
  output logic [1:0]        count
);

  logic [pWidth-1:0] entries [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries[0] <= '0;
      entries[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count_q    <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = entries[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/strobe_memory.sv
// Parametrised byte-lane data memory with strobed writes and a buffered,
// back-pressured read response channel.
module strobe_memory
  import strobe_memory_pkg::*;
#(
  parameter int unsigned pWords     = 128,
  parameter int unsigned pLanes     = 4,
  parameter int unsigned pAddrWidth = 32
) (
  input  logic                       iwClk,
  input  logic                       iwnRst,
  input  logic                       iwReadValid,
  output logic                       owReadReady,
  input  logic [pAddrWidth-1:0]      iwReadAddr,
  output logic                       orRespValid,
  input  logic                       iwRespReady,
  output logic [pLanes*BYTE_W-1:0]   orRespData,
  output logic                       orRespErr,
  input  logic                       iwWriteValid,
  input  logic [pAddrWidth-1:0]      iwWriteAddr,
  input  logic [pLanes*BYTE_W-1:0]   iwWriteData,
  input  logic [pLanes-1:0]          iwWstrb,
  output logic                       orWriteAck,
  output logic                       orWriteErr
);

  localparam int unsigned DATA_W = pLanes * BYTE_W;
  localparam int unsigned IDX_W  = (pWords > 1) ? clog2(pWords) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } resp_t;

  logic [DATA_W-1:0] mem [pWords];

  logic [IDX_W-1:0] wr_idx;
  logic             wr_err;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_err;

  always_comb begin
    decode_t wd;
    decode_t rd;
    wd     = decode_addr(64'(iwWriteAddr), pLanes, pWords);
    rd     = decode_addr(64'(iwReadAddr), pLanes, pWords);
    wr_idx = wd.index[IDX_W-1:0];
    wr_err = wd.err;
    rd_idx = rd.index[IDX_W-1:0];
    rd_err = rd.err;
  end

  // Array is deliberately not reset.
  always_ff @(posedge iwClk) begin
    if (iwWriteValid && !wr_err) begin
      for (int unsigned i = 0; i < pLanes; i++) begin
        if (iwWstrb[i]) mem[wr_idx][i*BYTE_W +: BYTE_W] <= iwWriteData[i*BYTE_W +: BYTE_W];
      end
    end
  end

  logic        accept;
  logic        pop;
  logic        inflight;
  resp_t       inflight_resp;
  resp_t       head;
  logic [1:0]  fifo_count;
  logic [2:0]  occupancy;

  assign accept = iwReadValid & owReadReady;

  // Array is sampled at the accepting edge, so a same-edge write is not seen.
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      inflight      <= 1'b0;
      inflight_resp <= '0;
      orWriteAck    <= 1'b0;
      orWriteErr    <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        inflight_resp.err  <= rd_err;
        inflight_resp.data <= rd_err ? '0 : mem[rd_idx];
      end
      orWriteAck <= iwWriteValid;
      orWriteErr <= iwWriteValid & wr_err;
    end
  end

  strobe_memory_resp_fifo #(
    .pWidth($bits(resp_t))
  ) u_resp_fifo (
    .clk       (iwClk),
    .rst_n     (iwnRst),
    .push      (inflight),
    .push_data (inflight_resp),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign orRespValid = (fifo_count != 2'd0);
  assign pop         = orRespValid & iwRespReady;
  assign occupancy   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign owReadReady = (occupancy < 3'd2);
  assign orRespData  = orRespValid ? head.data : '0;
  assign orRespErr   = orRespValid ? head.err : 1'b0;

endmodule
